// File: rtl/delay_line_var_if.sv
// Handshake-free bundle between a delay_line_var and its driver.
// The driver (master) owns stream and control inputs; the delay line (slave) owns the selected tap and fill status.
interface delay_line_var_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int SELW  = $clog2(DEPTH + 1)
);
    logic             en_i;
    logic             flush_i;
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic [SELW-1:0]  sel_i;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic [SELW-1:0]  fill_o;
    logic             primed_o;

    modport master (
        output en_i, flush_i, valid_i, data_i, sel_i,
        input  valid_o, data_o, fill_o, primed_o
    );

    modport slave (
        input  en_i, flush_i, valid_i, data_i, sel_i,
        output valid_o, data_o, fill_o, primed_o
    );
endinterface

// File: rtl/delay_line_var.sv
// Purpose: DEPTH-stage data+valid delay line with a per-cycle selectable output tap.
// Latency: 0..DEPTH enabled edges as chosen by sel_i (0 = combinational bypass).
// Backpressure: en_i=0 freezes every stage and the fill count; no ready is produced.
module delay_line_var #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    delay_line_var_if.slave bus
);
    localparam int SELW = $clog2(DEPTH + 1);
    localparam logic [SELW-1:0] DEPTH_S = SELW'(DEPTH);

    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [SELW-1:0]  fill;
    logic [SELW-1:0]  es;
    logic [WIDTH-1:0] tap_dat;
    logic             tap_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) d[k] <= '0;
            v    <= '0;
            fill <= '0;
        end else if (bus.flush_i) begin
            for (int k = 0; k < DEPTH; k++) d[k] <= '0;
            v    <= '0;
            fill <= '0;
        end else if (bus.en_i) begin
            d[0] <= bus.data_i;
            v[0] <= bus.valid_i;
            for (int k = 1; k < DEPTH; k++) begin
                d[k] <= d[k-1];
                v[k] <= v[k-1];
            end
            if (fill != DEPTH_S) fill <= fill + SELW'(1);
        end
    end

    // Out-of-range selects clamp to the deepest tap.
    assign es = (bus.sel_i > DEPTH_S) ? DEPTH_S : bus.sel_i;

    always_comb begin
        tap_dat = bus.data_i;
        tap_vld = bus.valid_i;
        for (int k = 1; k <= DEPTH; k++) begin
            if (es == SELW'(k)) begin
                tap_dat = d[k-1];
                tap_vld = v[k-1];
            end
        end
    end

    assign bus.data_o   = tap_dat;
    assign bus.valid_o  = tap_vld;
    assign bus.fill_o   = fill;
    assign bus.primed_o = (fill >= es);
endmodule

// File: tb/tb_delay_line_var.sv
// Directed bench for delay_line_var: DEPTH=8 and DEPTH=1 instances share one stimulus stream
// and are both compared every cycle against a log of accepted words.
module tb_delay_line_var;
    logic       clk = 1'b0;
    logic       rst;
    logic       en, flush, valid;
    logic [3:0] data;
    logic [3:0] sel;

    int tests = 0;
    int fails = 0;

    delay_line_var_if #(.WIDTH(4), .DEPTH(8)) bus8 ();
    delay_line_var_if #(.WIDTH(4), .DEPTH(1)) bus1 ();

    assign bus8.en_i    = en;
    assign bus8.flush_i = flush;
    assign bus8.valid_i = valid;
    assign bus8.data_i  = data;
    assign bus8.sel_i   = sel;
    assign bus1.en_i    = en;
    assign bus1.flush_i = flush;
    assign bus1.valid_i = valid;
    assign bus1.data_i  = data;
    assign bus1.sel_i   = sel[0:0];

    delay_line_var #(.WIDTH(4), .DEPTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    delay_line_var #(.WIDTH(4), .DEPTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Model: every word accepted since the last reset/flush, in order; n = enabled edges since then.
    logic [3:0] log_d [256];
    logic       log_v [256];
    int         n = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) n = 0;
        else if (flush) n = 0;
        else if (en) begin
            log_d[n] = data;
            log_v[n] = valid;
            n = n + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input int depth, input int s,
                       input logic [3:0] got_d, input logic got_v,
                       input logic [3:0] got_f, input logic got_p);
        int es, ef;
        logic [3:0] ed;
        logic ev;
        es = (s > depth) ? depth : s;
        ef = (n > depth) ? depth : n;
        if (es == 0) begin
            ed = data;
            ev = valid;
        end else if (n >= es) begin
            ed = log_d[n-es];
            ev = log_v[n-es];
        end else begin
            ed = 4'd0;
            ev = 1'b0;
        end
        check({tag, "_data"},   got_d, ed);
        check({tag, "_valid"},  got_v, ev);
        check({tag, "_fill"},   got_f, ef);
        check({tag, "_primed"}, got_p, (ef >= es));
    endtask

    always @(negedge clk) begin
        cmp("m8", 8, int'(sel), bus8.data_o, bus8.valid_o, bus8.fill_o, bus8.primed_o);
        cmp("m1", 1, int'(sel[0]), bus1.data_o, bus1.valid_o, {3'b000, bus1.fill_o}, bus1.primed_o);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; valid = 1'b0; data = 4'd0; sel = 4'd3;
        repeat (2) cyc();
        check("rst_valid", bus8.valid_o, 0);
        check("rst_fill",  bus8.fill_o, 0);
        check("rst_data",  bus8.data_o, 0);
        rst = 1'b0;

        // Fresh fill at tap 3
        en = 1'b1; valid = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            data = 4'(i);
            cyc();
            if (i == 2) begin
                check("s1_early_valid",  bus8.valid_o, 0);
                check("s1_early_primed", bus8.primed_o, 0);
            end
            if (i == 3) begin
                check("s1_first_data", bus8.data_o, 1);
                check("s1_primed",     bus8.primed_o, 1);
                check("s1_fill3",      bus8.fill_o, 3);
            end
            if (i == 4) check("s1_second_data", bus8.data_o, 2);
        end
        check("s1_fill_sat", bus8.fill_o, 8);

        // Bypass and clamp
        en = 1'b0; sel = 4'd0; data = 4'd9; valid = 1'b0;
        #1;
        check("s2_bypass_data",  bus8.data_o, 9);
        check("s2_bypass_valid", bus8.valid_o, 0);
        sel = 4'd15;
        #1;
        check("s2_clamp_data", bus8.data_o, 5);
        check("s2_clamp1_data", bus1.data_o, 12);

        // Stall holds the output
        sel = 4'd2; en = 1'b1; valid = 1'b1;
        data = 4'hA; cyc();
        data = 4'hB; cyc();
        data = 4'hC; cyc();
        check("s3_tap2", bus8.data_o, 4'hB);
        en = 1'b0; data = 4'hF;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("s3_stall_data", bus8.data_o, 4'hB);
            check("s3_stall_fill", bus8.fill_o, 8);
        end
        en = 1'b1;
        data = 4'hD; cyc();
        check("s3_resume_c", bus8.data_o, 4'hC);
        data = 4'hE; cyc();
        check("s3_resume_d", bus8.data_o, 4'hD);

        // Flush with enable discards the presented word
        flush = 1'b1; en = 1'b1; data = 4'h5; valid = 1'b1;
        cyc();
        flush = 1'b0; en = 1'b0; sel = 4'd3;
        #1;
        check("s4_valid",  bus8.valid_o, 0);
        check("s4_fill",   bus8.fill_o, 0);
        check("s4_primed", bus8.primed_o, 0);
        en = 1'b1; data = 4'h6;
        for (int i = 1; i <= 9; i++) begin
            sel = 4'(i);
            cyc();
        end
        flush = 1'b1; en = 1'b0;
        cyc();
        flush = 1'b0;
        #1;
        check("s4_flush_noen_fill", bus8.fill_o, 0);

        // Bubbles survive the pipeline
        sel = 4'd4; en = 1'b1;
        for (int j = 0; j < 10; j++) begin
            valid = (j < 5) ? pat[j] : 1'b0;
            data  = 4'(j + 1);
            cyc();
            if (j >= 3 && j <= 7) check("s5_bubble", bus8.valid_o, pat[j-3]);
        end

        // Async reset mid-stream, then a fresh fill
        valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data = 4'(i);
            cyc();
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("s6_async_valid",  bus8.valid_o, 0);
        check("s6_async_fill",   bus8.fill_o, 0);
        check("s6_async_primed", bus8.primed_o, 0);
        @(posedge clk);
        #2;
        rst = 1'b0; sel = 4'd3;
        for (int i = 1; i <= 4; i++) begin
            data = 4'(i);
            cyc();
            if (i == 2) check("s6_refill_early", bus8.valid_o, 0);
            if (i == 3) check("s6_refill_first", bus8.data_o, 1);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
